cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Sequences and shares one single-ported main data memory between two cache refill/write-through requesters: the instruction-side port (I) and the data-side cache port (D).
- Accepts one transaction at a time.
- Drives the memory for one issue cycle and waits a fixed read latency.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the instruction cache, the 2-way data cache and the data_mem instance.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MEM_LATENCY, 2, cycles from the memory issue cycle until mem_rdata is valid; legal range 0..15

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
i_req  in  1  I-side read request; held high until i_ack
i_addr  in  ADDR_WIDTH  I-side word address
i_rdata  out  DATA_WIDTH  I-side read data; valid while i_ack=1
i_ack  out  1  one-cycle completion pulse to I
d_req  in  1  D-side request; held high until d_ack
d_we  in  1  D-side write (1) or read (0)
d_addr_mode  in  3  D-side access size code, passed to the memory unchanged
d_addr  in  ADDR_WIDTH  D-side byte address
d_wdata  in  DATA_WIDTH  D-side write data
d_rdata  out  DATA_WIDTH  D-side read data; valid while d_ack=1
d_ack  out  1  one-cycle completion pulse to D
mem_en  out  1  memory access strobe; high only in ISSUE
mem_we  out  1  memory write enable; high only in ISSUE for a write
mem_addr_mode  out  3  access size to memory
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst sampled high at posedge):
  - State goes to IDLE.
  - i_ack, d_ack, mem_en, mem_we and busy go to 0.
  - i_rdata, d_rdata and all latched request registers go to 0.
  - last_grant goes to D, so I wins the first tie.
  - Reset mid-transaction abandons the transaction: no ack is issued and the memory strobe drops the same edge.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is pending, stay.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that is not last_grant (round-robin), then update last_grant.
  - On grant, latch addr, we, addr_mode and wdata into internal registers. I-side always uses we=0 and addr_mode = word code (3'b010). Go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive mem_en=1, mem_we=latched we, and mem_addr/mem_addr_mode/mem_wdata from the latches.
  - Write: go to DONE.
  - Read with MEM_LATENCY=0: capture mem_rdata this cycle, go to DONE.
  - Read with MEM_LATENCY>0: load a 4-bit counter with MEM_LATENCY, go to WAIT.
- WAIT:
  - mem_en=0; mem_addr etc. hold their latched values.
  - Counter decrements each cycle.
  - In the cycle where counter==1, capture mem_rdata into the granted port's rdata register and go to DONE.
- DONE:
  - Assert the granted port's ack for exactly one cycle; rdata is valid alongside it (0 for writes, unchanged from the previous value is not allowed).
  - Return to IDLE.
- Latency, with a request sampled in IDLE at cycle N:
  - Write: ISSUE at N+1, ack at N+2.
  - Read: ack at N+2+MEM_LATENCY.
  - A requester may drop req in its ack cycle. A back-to-back request is re-sampled in IDLE the cycle after DONE, giving a minimum 3-cycle transaction spacing.
- Other cases:
  - A losing requester keeps req high and is served next, with no starvation.
  - A request dropped before ack is a protocol violation. The latched transaction still completes and the ack is still pulsed.
  - i_ack and d_ack are never high in the same cycle.
  - An ack never appears without a prior grant.
  - Address and data inputs are ignored outside IDLE.

Optional Feature:
Macro ARB_DCACHE_PRIO_EN.
- Defined: fixed priority; D always wins a tie in IDLE, and last_grant is unused. I can starve only while D requests continuously.
- Undefined: round-robin as above.

Test Plan:
- Reset, then single I read at 0x0000_0040 with MEM_LATENCY=2 and mem_rdata=0xDEADBEEF at the right cycle -> mem_en one cycle at N+1, i_ack at N+4, i_rdata=0xDEADBEEF.
- D write to 0x0000_0104, d_addr_mode=3'b000, d_wdata=0x000000A5 -> mem_en=1, mem_we=1, mem_addr=0x104, mem_addr_mode=0 at N+1; d_ack at N+2; no i_ack.
- i_req and d_req asserted together and held for 4 transactions -> grant order I, D, I, D. With ARB_DCACHE_PRIO_EN -> order D, D, D, D until d_req drops.
- MEM_LATENCY=0 D read returning 0x12345678 -> d_ack at N+2, d_rdata=0x12345678.
- rst pulsed during WAIT of an I read -> next cycle busy=0, no i_ack ever issued for it, and the following simultaneous request is granted to I.
- d_req dropped during WAIT -> d_ack still pulses once, and busy returns to 0 after DONE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one single-ported main data memory between the instruction-side
// refill port (I) and the data-cache port (D). One transaction is in flight
// at a time. Each transaction follows the same sequence:
//   1. The memory is driven for a single ISSUE cycle.
//   2. For reads, the arbiter waits MEM_LATENCY cycles for mem_rdata.
//   3. The granted port receives a one-cycle ack with its rdata.
//
// Build option:
//   ARB_DCACHE_PRIO_EN  defined   -> D wins every tie in IDLE (fixed priority)
//                       undefined -> round-robin between I and D on a tie
//
// Parameters:
//   ADDR_WIDTH   address width of all ports
//   DATA_WIDTH   data width of all ports
//   MEM_LATENCY  cycles from the memory issue cycle until mem_rdata is valid
//                (0..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             I-side read request and word address
//   i_rdata/i_ack            I-side read data and completion pulse
//   d_req/d_we/d_addr_mode   D-side request, write flag, access size code
//   d_addr/d_wdata           D-side byte address and write data
//   d_rdata/d_ack            D-side read data and completion pulse
//   mem_en/mem_we            memory strobe and write enable (ISSUE only)
//   mem_addr_mode/mem_addr   access size and address to memory
//   mem_wdata/mem_rdata      memory write and read data
//   busy                     high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_addr_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [2:0]            mem_addr_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] WORD_MODE = 3'b010;
    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY);

    state_t                state;
    state_t                state_next;

    // Transaction latched at grant time; the request inputs are ignored
    // until the arbiter is back in IDLE.
    logic                  sel_d;      // 1: D owns the transaction, 0: I
    logic                  lat_we;
    logic [2:0]            lat_mode;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            wait_cnt;

`ifndef ARB_DCACHE_PRIO_EN
    // Owner of the most recent grant; the other side wins the next tie.
    logic                  last_grant_d;
`endif

    logic                  grant;
    logic                  grant_d;
    logic                  capture;

    // -----------------------------------------------------------------------
    // Next-state and grant decision
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant = 1'b1;
`ifdef ARB_DCACHE_PRIO_EN
                    grant_d = d_req;
`else
                    grant_d = d_req && (!i_req || !last_grant_d);
`endif
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (lat_we) begin
                    state_next = DONE;
                end else if (MEM_LATENCY == 0) begin
                    // Zero-latency memory answers in the issue cycle itself.
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                // Counter was loaded with MEM_LATENCY in ISSUE, so reaching 1
                // marks the cycle in which mem_rdata becomes valid.
                if (wait_cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Transaction latches, latency counter and read-data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_d        <= 1'b0;
            lat_we       <= 1'b0;
            lat_mode     <= 3'b000;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            wait_cnt     <= 4'd0;
            i_rdata      <= '0;
            d_rdata      <= '0;
`ifndef ARB_DCACHE_PRIO_EN
            last_grant_d <= 1'b1;  // I wins the first tie after reset
`endif
        end else begin
            if (grant) begin
                sel_d <= grant_d;
`ifndef ARB_DCACHE_PRIO_EN
                last_grant_d <= grant_d;
`endif
                if (grant_d) begin
                    lat_we    <= d_we;
                    lat_mode  <= d_addr_mode;
                    lat_addr  <= d_addr;
                    lat_wdata <= d_wdata;
                end else begin
                    lat_we    <= 1'b0;
                    lat_mode  <= WORD_MODE;
                    lat_addr  <= i_addr;
                    lat_wdata <= '0;
                end
            end

            if (state == ISSUE) begin
                wait_cnt <= LAT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // A write acks with zero data rather than whatever the port's
            // rdata register held from an earlier read.
            if (capture) begin
                if (sel_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end else if (state == ISSUE && lat_we) begin
                if (sel_d) begin
                    d_rdata <= '0;
                end else begin
                    i_rdata <= '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: memory strobes only in ISSUE, acks only in DONE
    // -----------------------------------------------------------------------
    assign mem_en        = (state == ISSUE);
    assign mem_we        = (state == ISSUE) && lat_we;
    assign mem_addr_mode = lat_mode;
    assign mem_addr      = lat_addr;
    assign mem_wdata     = lat_wdata;
    assign busy          = (state != IDLE);
    assign i_ack         = (state == DONE) && !sel_d;
    assign d_ack         = (state == DONE) && sel_d;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Bench for cache_mem_arbiter. Two instances are used:
//   dut   MEM_LATENCY=2, checked every cycle against a transaction-timeline
//         model, plus directed literal expectations
//   dut0  MEM_LATENCY=0, directed literal expectations only
//
// The memory is a behavioural responder. It returns the correct word only in
// the cycle the data is due, and the bit-inverse word in every other cycle.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_addr_mode;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_addr_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        i0_req;
    logic [31:0] i0_addr;
    logic [31:0] i0_rdata;
    logic        i0_ack;
    logic        d0_req;
    logic        d0_we;
    logic [2:0]  d0_mode;
    logic [31:0] d0_addr;
    logic [31:0] d0_wdata;
    logic [31:0] d0_rdata;
    logic        d0_ack;
    logic        m0_en;
    logic        m0_we;
    logic [2:0]  m0_mode;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        busy0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    int n_iack   = 0;
    int n_dack   = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr_mode(d_addr_mode), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr_mode(mem_addr_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i0_req), .i_addr(i0_addr), .i_rdata(i0_rdata), .i_ack(i0_ack),
        .d_req(d0_req), .d_we(d0_we), .d_addr_mode(d0_mode), .d_addr(d0_addr),
        .d_wdata(d0_wdata), .d_rdata(d0_rdata), .d_ack(d0_ack),
        .mem_en(m0_en), .mem_we(m0_we), .mem_addr_mode(m0_mode),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata),
        .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen by both instances.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0200) return 32'h1234_5678;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Responder for dut: valid data exactly LAT cycles after the issue cycle.
    int          iss_c = -100;
    logic [31:0] iss_a = '0;
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            iss_c <= cyc;
            iss_a <= mem_addr;
        end
    end
    assign mem_rdata = (cyc == iss_c + LAT) ? word(iss_a) : ~word(mem_addr);

    // Responder for dut0: valid data in the issue cycle itself.
    assign m0_rdata = (m0_en === 1'b1) ? word(m0_addr) : ~word(m0_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Timeline model of dut. Each granted transaction is described by:
    //   issue cycle  grant cycle + 1
    //   ack cycle    grant cycle + 2, plus LAT for reads
    // All outputs are derived from those two cycle numbers.
    // -----------------------------------------------------------------------
    bit          m_act    = 0;
    bit          m_port_d = 0;
    bit          m_last_d = 1;
    bit          m_we     = 0;
    logic [2:0]  m_mode   = '0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    int          m_issue  = 0;
    int          m_ack    = 0;

    always @(posedge clk) begin
        bit          s_rst, s_i, s_d, s_we, was_idle, pick_d;
        logic [2:0]  s_mode;
        logic [31:0] s_ia, s_da, s_wd;
        int          k;
        s_rst = rst; s_i = i_req; s_d = d_req; s_we = d_we;
        s_mode = d_addr_mode; s_ia = i_addr; s_da = d_addr; s_wd = d_wdata;
        k = cyc + 1;
        if (s_rst) begin
            m_act    = 0;
            m_last_d = 1;
        end else begin
            was_idle = !m_act;
            if (m_act && (k - 1) == m_ack) m_act = 0;
            if (was_idle && (s_i || s_d)) begin
`ifdef ARB_DCACHE_PRIO_EN
                pick_d = s_d;
`else
                pick_d = s_d && (!s_i || !m_last_d);
`endif
                m_act    = 1;
                m_port_d = pick_d;
                m_last_d = pick_d;
                m_we     = pick_d ? s_we : 1'b0;
                m_mode   = pick_d ? s_mode : 3'b010;
                m_addr   = pick_d ? s_da : s_ia;
                m_wdata  = s_wd;
                m_issue  = k;
                m_ack    = k + 1 + (m_we ? 0 : LAT);
            end
        end
        #1;
        if (i_ack === 1'b1) n_iack++;
        if (d_ack === 1'b1) n_dack++;
        if (chk_en) begin
            chk("busy", busy, m_act);
            chk("mem_en", mem_en, m_act && cyc == m_issue);
            chk("mem_we", mem_we, m_act && cyc == m_issue && m_we);
            chk("i_ack", i_ack, m_act && cyc == m_ack && !m_port_d);
            chk("d_ack", d_ack, m_act && cyc == m_ack && m_port_d);
            if (m_act) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_addr_mode", mem_addr_mode, m_mode);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                if (cyc == m_ack) begin
                    if (m_port_d) chk("d_rdata", d_rdata, m_we ? 32'h0 : word(m_addr));
                    else          chk("i_rdata", i_rdata, word(m_addr));
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus, driven and observed on the falling edge
    // -----------------------------------------------------------------------
    logic        s_iss_we;
    logic [31:0] s_iss_addr;
    logic [2:0]  s_iss_mode;
    logic [31:0] s_iss_wd;

    task automatic txn(input bit is_d, input bit we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int drop_at,
                       output int t_iss, output int t_ack, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        n = cyc; t_iss = -1; t_ack = -1; rdata = '0;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr_mode = mode; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1; i_addr = addr;
        end
        for (int k = 0; k < 40 && t_ack < 0; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1 && t_iss < 0) begin
                t_iss = cyc - n;
                s_iss_we = mem_we; s_iss_addr = mem_addr;
                s_iss_mode = mem_addr_mode; s_iss_wd = mem_wdata;
            end
            if ((is_d ? d_ack : i_ack) === 1'b1) begin
                t_ack = cyc - n;
                rdata = is_d ? d_rdata : i_rdata;
                if (is_d) d_req = 0; else i_req = 0;
            end
            if (drop_at >= 0 && (cyc - n) == drop_at) begin
                if (is_d) d_req = 0; else i_req = 0;
            end
        end
        if (t_ack < 0) begin
            checks++; failures++;
            $display("FAIL ack_timeout: actual=none required=ack within 40 cycles");
            i_req = 0; d_req = 0;
        end
    endtask

    task automatic both_run(input int ntx, input bit drop_on_ack,
                            output logic [7:0] ord, output int got);
        ord = '0; got = 0;
        @(negedge clk);
        i_req = 1; i_addr = 32'h0000_0080;
        d_req = 1; d_we = 0; d_addr_mode = 3'b010; d_addr = 32'h0000_0180; d_wdata = '0;
        for (int k = 0; k < 200 && got < ntx; k++) begin
            @(negedge clk);
            if (i_ack === 1'b1) begin
                ord[got] = 1'b0; got++;
                if (drop_on_ack) i_req = 0;
            end
            if (d_ack === 1'b1) begin
                ord[got] = 1'b1; got++;
                if (drop_on_ack) d_req = 0;
            end
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    bit          tab_d    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit          tab_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  tab_mode [4] = '{3'b010, 3'b001, 3'b100, 3'b010};
    logic [31:0] tab_addr [4] = '{32'h0000_1000, 32'h0000_2002, 32'h0000_2004, 32'h0000_0040};
    logic [31:0] tab_wd   [4] = '{32'h0, 32'h0000_BEEF, 32'h0, 32'h0};

    initial begin
        int          t_iss, t_ack, got, n, base, t0_iss, t0_ack;
        logic [31:0] rd, r0;
        logic [7:0]  ord;

        rst = 1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr_mode = '0; d_addr = '0; d_wdata = '0;
        i0_req = 0; i0_addr = '0; d0_req = 0; d0_we = 0; d0_mode = '0; d0_addr = '0; d0_wdata = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // Single I read, latency 2
        txn(0, 0, 3'b010, 32'h0000_0040, 32'h0, -1, t_iss, t_ack, rd);
        chk("iread_issue_ofs", t_iss, 1);
        chk("iread_ack_ofs", t_ack, 4);
        chk("iread_data", rd, 32'hDEAD_BEEF);
        chk("iread_mode", s_iss_mode, 3'b010);

        // D byte write
        base = n_iack;
        txn(1, 1, 3'b000, 32'h0000_0104, 32'h0000_00A5, -1, t_iss, t_ack, rd);
        chk("dwrite_issue_ofs", t_iss, 1);
        chk("dwrite_ack_ofs", t_ack, 2);
        chk("dwrite_mem_we", s_iss_we, 1);
        chk("dwrite_mem_addr", s_iss_addr, 32'h0000_0104);
        chk("dwrite_mem_mode", s_iss_mode, 3'b000);
        chk("dwrite_mem_wdata", s_iss_wd, 32'h0000_00A5);
        chk("dwrite_rdata_zero", rd, 32'h0);
        chk("dwrite_no_iack", n_iack - base, 0);

        // Simultaneous requests held for four transactions
        do_reset();
        both_run(4, 1'b0, ord, got);
        chk("tie_count", got, 4);
`ifdef ARB_DCACHE_PRIO_EN
        chk("tie_order", ord[3:0], 4'b1111);
`else
        chk("tie_order", ord[3:0], 4'b1010);
`endif

        // Zero-latency D read on dut0
        @(negedge clk);
        d0_req = 1; d0_we = 0; d0_mode = 3'b010; d0_addr = 32'h0000_0200;
        n = cyc; t0_iss = -1; t0_ack = -1; r0 = '0;
        for (int k = 0; k < 10 && t0_ack < 0; k++) begin
            @(negedge clk);
            if (m0_en === 1'b1 && t0_iss < 0) begin
                t0_iss = cyc - n;
                chk("l0_mem_we", m0_we, 0);
                chk("l0_mem_mode", m0_mode, 3'b010);
                chk("l0_mem_wdata", m0_wdata, 0);
            end
            if (d0_ack === 1'b1) begin
                t0_ack = cyc - n; r0 = d0_rdata; d0_req = 0;
            end
        end
        d0_req = 0;
        chk("l0_issue_ofs", t0_iss, 1);
        chk("l0_ack_ofs", t0_ack, 2);
        chk("l0_data", r0, 32'h1234_5678);
        @(negedge clk);
        chk("l0_busy_after", busy0, 0);
        chk("l0_no_iack", i0_ack, 0);
        chk("l0_i_rdata", i0_rdata, 0);

        // Reset while an I read is waiting for memory
        @(negedge clk);
        i_req = 1; i_addr = 32'h0000_0044;
        @(negedge clk);
        chk("rstw_issue", mem_en, 1);
        @(negedge clk);
        chk("rstw_busy_wait", busy, 1);
        chk("rstw_en_wait", mem_en, 0);
        base = n_iack;
        rst = 1; i_req = 0;
        @(negedge clk);
        rst = 0;
        chk("rstw_busy_after", busy, 0);
        chk("rstw_en_after", mem_en, 0);
        repeat (6) @(negedge clk);
        chk("rstw_no_iack", n_iack - base, 0);
        both_run(2, 1'b1, ord, got);
        chk("rstw_count", got, 2);
`ifdef ARB_DCACHE_PRIO_EN
        chk("rstw_order", ord[1:0], 2'b01);
`else
        chk("rstw_order", ord[1:0], 2'b10);
`endif

        // D read whose request is dropped during WAIT
        base = n_dack;
        txn(1, 0, 3'b010, 32'h0000_0300, 32'h0, 2, t_iss, t_ack, rd);
        chk("ddrop_ack_ofs", t_ack, 4);
        chk("ddrop_data", rd, 32'h5A5A_0300);
        @(negedge clk);
        chk("ddrop_busy_after", busy, 0);
        repeat (4) @(negedge clk);
        chk("ddrop_one_ack", n_dack - base, 1);

        // Mixed directed transactions
        for (int e = 0; e < 4; e++) begin
            txn(tab_d[e], tab_we[e], tab_mode[e], tab_addr[e], tab_wd[e], -1, t_iss, t_ack, rd);
            chk("mix_issue_ofs", t_iss, 1);
            chk("mix_ack_ofs", t_ack, tab_we[e] ? 2 : 2 + LAT);
            chk("mix_data", rd, tab_we[e] ? 32'h0 : word(tab_addr[e]));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
